// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: redirect request, memory request/response channel
// and the instruction queue head presented to the core.
interface ifetch_queue_if;
   logic       redirect;
   logic [7:0] redir_page;
   logic [7:0] redir_pc;
   logic       mem_req;
   logic [7:0] mem_page;
   logic [7:0] mem_addr;
   logic       mem_gnt;
   logic       mem_rvalid;
   logic [7:0] mem_rdata;
   logic       inst_valid;
   logic [7:0] inst;
   logic [7:0] inst_pc;
   logic       inst_ready;

   modport master (
      input  redirect, redir_page, redir_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
      output mem_req, mem_page, mem_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect, redir_page, redir_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
      input  mem_req, mem_page, mem_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues byte fetches from (fpage, fpc), buffers the
// in-order responses and presents the head instruction to the core.
module ifetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   ifetch_queue_if.master bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]    fpage;
   logic [7:0]    fpc;
   logic [7:0]    rpc;
   logic [CW-1:0] occ;
   logic [CW-1:0] outst;
   logic [CW-1:0] discard;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [7:0]    q_data [DEPTH];
   logic [7:0]    q_pc   [DEPTH];

   logic          req;
   logic          grant;
   logic          resp;
   logic          push;
   logic          pop;
   logic [CW:0]   inflight;
   logic [CW-1:0] outst_resp;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Queued plus in-flight bytes bound the request rate, so pushes never overflow.
   assign inflight   = {1'b0, occ} + {1'b0, outst};
   assign req        = rst_n && !bus.redirect && (inflight < (CW + 1)'(DEPTH));
   assign grant      = req && bus.mem_gnt;
   assign resp       = bus.mem_rvalid && (outst != '0);
   assign push       = resp && (discard == '0) && !bus.redirect;
   assign pop        = (occ != '0) && bus.inst_ready && !bus.redirect;
   assign outst_resp = outst - CW'(resp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpage   <= '0;
         fpc     <= '0;
         rpc     <= '0;
         occ     <= '0;
         outst   <= '0;
         discard <= '0;
         head    <= '0;
         tail    <= '0;
      end else begin
         outst <= outst_resp + CW'(grant);
         if (bus.redirect) begin
            fpage   <= bus.redir_page;
            fpc     <= bus.redir_pc;
            rpc     <= bus.redir_pc;
            occ     <= '0;
            head    <= '0;
            tail    <= '0;
            // Every byte still in flight belongs to the old stream.
            discard <= outst_resp;
         end else begin
            if (grant) fpc <= fpc + 8'd1;
            if (resp && (discard != '0)) discard <= discard - CW'(1);
            if (push) begin
               rpc  <= rpc + 8'd1;
               tail <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
            occ <= occ + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_data[tail] <= bus.mem_rdata;
         q_pc[tail]   <= rpc;
      end
   end

   assign bus.mem_req    = req;
   assign bus.mem_page   = fpage;
   assign bus.mem_addr   = fpc;
   assign bus.inst_valid = (occ != '0);
   assign bus.inst       = (occ != '0) ? q_data[head] : 8'd0;
   assign bus.inst_pc    = (occ != '0) ? q_pc[head]   : 8'd0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: epoch-tagged memory/queue model compared every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_ifetch_queue;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ifetch_queue_if bus();
   ifetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

   typedef struct {logic [7:0] page; logic [7:0] addr; int epoch; int due;} req_t;
   typedef struct {logic [7:0] data; logic [7:0] pc; int cyc;} ent_t;
   typedef struct {logic [7:0] page; logic [7:0] addr;} fetch_t;

   logic [7:0] mem [65536];
   req_t   pending[$];
   ent_t   expq[$];
   ent_t   pop_log[$];
   fetch_t grant_log[$];

   logic [7:0] m_page, m_pc;
   int  epoch = 0, cyc = 0;
   int  checks = 0, errors = 0;
   int  gnt_pct = 100, rv_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
   int  redir_cyc = 0, lat_meas = -1;
   bit  watch_valid = 1'b0;

   logic [7:0] s1_exp [6] = '{8'hC1, 8'hC2, 8'hC8, 8'hCB, 8'h72, 8'h01};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: requests carry the redirect epoch they were issued in;
   // only responses from the current epoch become instructions.
   req_t   mr;
   ent_t   me;
   fetch_t mf;
   bit     exp_req, mgrant;
   always @(negedge clk) begin
      if (!rst_n) begin
         pending.delete();
         expq.delete();
         m_page = 8'd0;
         m_pc   = 8'd0;
         chk("rst_mem_req", bus.mem_req, 0);
         chk("rst_mem_page", bus.mem_page, 0);
         chk("rst_mem_addr", bus.mem_addr, 0);
         chk("rst_inst_valid", bus.inst_valid, 0);
         chk("rst_inst", bus.inst, 0);
         chk("rst_inst_pc", bus.inst_pc, 0);
      end else begin
         exp_req = (expq.size() + pending.size() < DEPTH) && !bus.redirect;
         chk("mem_req", bus.mem_req, exp_req);
         chk("mem_page", bus.mem_page, m_page);
         chk("mem_addr", bus.mem_addr, m_pc);
         chk("inst_valid", bus.inst_valid, expq.size() != 0);
         if (expq.size() != 0) begin
            chk("inst", bus.inst, expq[0].data);
            chk("inst_pc", bus.inst_pc, expq[0].pc);
         end
         if (bus.mem_rvalid) chk("rvalid_has_outstanding", pending.size() != 0, 1);
         if (watch_valid && bus.inst_valid) begin
            lat_meas    = cyc - redir_cyc;
            watch_valid = 1'b0;
         end
         mgrant = exp_req && bus.mem_gnt;
         if (expq.size() != 0 && bus.inst_ready && !bus.redirect) begin
            me     = expq.pop_front();
            me.cyc = cyc;
            pop_log.push_back(me);
         end
         if (bus.mem_rvalid && pending.size() != 0) begin
            mr = pending.pop_front();
            if (mr.epoch == epoch && !bus.redirect) begin
               me.data = mem[{mr.page, mr.addr}];
               me.pc   = mr.addr;
               me.cyc  = 0;
               expq.push_back(me);
            end
         end
         if (bus.redirect) begin
            expq.delete();
            epoch++;
            m_page      = bus.redir_page;
            m_pc        = bus.redir_pc;
            redir_cyc   = cyc;
            watch_valid = 1'b1;
         end else if (mgrant) begin
            mr.page  = m_page;
            mr.addr  = m_pc;
            mr.epoch = epoch;
            mr.due   = cyc + int'($urandom_range(lat_max, lat_min));
            pending.push_back(mr);
            mf.page = m_page;
            mf.addr = m_pc;
            grant_log.push_back(mf);
            m_pc = m_pc + 8'd1;
         end
      end
      cyc++;
   end

   // Memory: in-order responses once each request's latency has elapsed.
   initial begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 8'd0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = 8'($urandom);
         if (rst_n && pending.size() != 0 && pending[0].due <= cyc &&
             $urandom_range(99) < rv_pct) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem[{pending[0].page, pending[0].addr}];
         end
      end
   end

   task automatic drive();
      bus.mem_gnt    = ($urandom_range(99) < gnt_pct);
      bus.inst_ready = ($urandom_range(99) < rdy_pct);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         drive();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic redir(input logic [7:0] p, input logic [7:0] a);
      bus.redirect   = 1'b1;
      bus.redir_page = p;
      bus.redir_pc   = a;
      step(1);
      bus.redirect   = 1'b0;
   endtask

   task automatic wait_pending(input string name, input int n);
      int k = 0;
      while (pending.size() < n && k < 50) begin
         step(1);
         k++;
      end
      chk(name, pending.size() >= n, 1);
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!bus.inst_valid && k < 50) begin
         step(1);
         k++;
      end
      chk(name, bus.inst_valid, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int base;
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) mem[i] = s1_exp[i];
      mem[{8'd2, 8'h10}] = 8'hA5;
      mem[{8'd4, 8'h80}] = 8'h5C;
      bus.redirect   = 1'b0;
      bus.redir_page = 8'd0;
      bus.redir_pc   = 8'd0;
      bus.mem_gnt    = 1'b0;
      bus.inst_ready = 1'b0;
      rst_n = 1'b0;
      step(3);

      // Streaming fill from page 0 after reset release.
      drive();
      base  = pop_log.size();
      rst_n = 1'b1;
      step(12);
      chk("s1_pop_count", pop_log.size() - base >= 6, 1);
      for (int i = 0; i < 6; i++) begin
         chk("s1_inst", pop_log[base + i].data, s1_exp[i]);
         chk("s1_inst_pc", pop_log[base + i].pc, i);
         if (i > 0) chk("s1_one_per_cycle", pop_log[base + i].cyc - pop_log[base + i - 1].cyc, 1);
      end

      // Core stalled: queue fills to DEPTH, then requests stop.
      rdy_pct = 0;
      do_reset();
      base = grant_log.size();
      step(12);
      chk("s2_grants", grant_log.size() - base, DEPTH);
      chk("s2_mem_req_low", bus.mem_req, 0);
      chk("s2_inst_valid", bus.inst_valid, 1);
      rdy_pct = 100;
      step(20);

      // Redirect with two slow responses in flight.
      lat_min = 3; lat_max = 3;
      do_reset();
      wait_pending("s3_outstanding", 2);
      chk("s3_outstanding_exact", pending.size(), 2);
      redir(8'd2, 8'h10);
      wait_valid("s3_valid_timeout");
      chk("s3_inst", bus.inst, 8'hA5);
      chk("s3_inst_pc", bus.inst_pc, 8'h10);
      step(10);

      // Address wrap within a page, plus minimum redirect latency.
      lat_min = 1; lat_max = 1;
      do_reset();
      step(3);
      base = grant_log.size();
      redir(8'd1, 8'hFE);
      step(8);
      chk("s4_grant_count", grant_log.size() - base >= 3, 1);
      chk("s4_addr0", {grant_log[base].page, grant_log[base].addr}, 16'h01FE);
      chk("s4_addr1", {grant_log[base + 1].page, grant_log[base + 1].addr}, 16'h01FF);
      chk("s4_addr2", {grant_log[base + 2].page, grant_log[base + 2].addr}, 16'h0100);
      chk("s4_redirect_latency", lat_meas, 3);

      // Reset mid-stream with two requests outstanding.
      lat_min = 3; lat_max = 3;
      do_reset();
      wait_pending("s5_outstanding", 2);
      rst_n = 1'b0;
      #1;
      chk("s5_mem_req", bus.mem_req, 0);
      chk("s5_mem_page", bus.mem_page, 0);
      chk("s5_mem_addr", bus.mem_addr, 0);
      chk("s5_inst_valid", bus.inst_valid, 0);
      chk("s5_inst", bus.inst, 0);
      chk("s5_inst_pc", bus.inst_pc, 0);
      step(2);
      rst_n = 1'b1;
      #1;
      chk("s5_first_req", bus.mem_req, 1);
      chk("s5_first_addr", {bus.mem_page, bus.mem_addr}, 16'h0000);
      step(10);

      // Back-to-back redirects with responses pending.
      wait_pending("s6_outstanding", 2);
      redir(8'd3, 8'h40);
      redir(8'd4, 8'h80);
      wait_valid("s6_valid_timeout");
      chk("s6_inst_pc", bus.inst_pc, 8'h80);
      chk("s6_inst", bus.inst, 8'h5C);

      // Randomized traffic, redirects and occasional resets.
      lat_min = 1; lat_max = 4;
      gnt_pct = 70; rv_pct = 70; rdy_pct = 60;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(999) < 30) begin
            redir(8'($urandom), 8'($urandom));
         end else if ($urandom_range(999) < 3) begin
            rst_n = 1'b0;
            step(1 + $urandom_range(1));
            rst_n = 1'b1;
         end else begin
            step(1);
         end
      end
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
